pattern_scan_ctrl: RTL and testbench
====================================

Name: pattern_scan_ctrl

Overview:
Controller that accepts parallel words over a valid/ready handshake and serialises each word MSB-first through an internal Mealy pattern matcher. The matcher detects a run-time-programmable PAT_W-bit pattern, with overlapping matches allowed. The controller counts matches per word and reports the result over a second valid/ready handshake. It sits between a word-producing datapath and status/interrupt logic, and sequences the bit-serial detector so upstream blocks never drive serial bits directly.

Parameters:
DATA_W, 16, bits per input word; must satisfy PAT_W <= DATA_W.
PAT_W, 4, pattern length in bits; must be >= 2.
CNT_W, 5, hit counter width; saturates at 2^CNT_W-1.
IDX_W (localparam), clog2(DATA_W), width of bit-index fields.

Ports:
clk  in  1  clock, rising edge
reset  in  1  reset, asynchronous, active-high
cfg_pattern  in  PAT_W  pattern to match; MSB is the first bit in time; latched at word accept
in_valid  in  1  input word valid
in_ready  out  1  controller can accept a word
in_data  in  DATA_W  word to scan; bit DATA_W-1 is scanned first
bit_out  out  1  bit being scanned this cycle; 0 when not in SHIFT
hit  out  1  Mealy strobe; high in the SHIFT cycle whose bit completes a match
busy  out  1  high in SHIFT and DONE
out_valid  out  1  result valid
out_ready  in  1  result consumer ready
hit_count  out  CNT_W  matches in the last word, saturating
first_hit_idx  out  IDX_W  scan index (0 = first bit) of the bit completing the first match; 0 if none
no_hit  out  1  high with out_valid when hit_count == 0

Behaviour:
- States: IDLE, SHIFT, DONE. Reset drives the FSM to IDLE.
- Reset values: in_ready=1, all other outputs 0, internal shift/history/counters 0.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready:
    - latch in_data into the shift register and cfg_pattern into the pattern register;
    - clear history, bit index, hit_count and first_hit_idx;
    - go to SHIFT.
- SHIFT:
  - in_ready=0. One bit per cycle; bit_out = shift register MSB; the shift register shifts left each cycle.
  - Window = {history[PAT_W-2:0], bit_out}.
  - hit = (window == pattern) & (index >= PAT_W-1). hit is combinational from registered state and the current bit.
  - On hit: hit_count increments, saturating. If this is the first hit of the word, first_hit_idx <= index.
  - After the cycle with index == DATA_W-1, go to DONE.
  - Exactly DATA_W SHIFT cycles per word.
- DONE:
  - out_valid=1; no_hit=(hit_count==0).
  - hit_count, first_hit_idx and no_hit are held stable while out_ready=0.
  - On out_ready: go to IDLE. in_ready is 1 on the next cycle.
- Latency: word accepted at edge T; SHIFT occupies cycles T+1..T+DATA_W; out_valid is high from T+DATA_W+1.
- History is cleared per word. Matches never span word boundaries.
- cfg_pattern changes outside the accept cycle have no effect on the word in flight.
- in_valid is ignored while busy. No accept occurs in the same cycle as the DONE->IDLE handshake.
- Reset mid-SHIFT or mid-DONE aborts the word. No out_valid is produced for it, and outputs take their reset values immediately.

Optional Feature:
Macro PATTERN_SCAN_IRQ_EN.
- Defined:
  - adds port irq (out, 1) and port irq_clr (in, 1);
  - irq is a sticky flag, set on entry to DONE when hit_count > 0;
  - irq_clr clears it; if set and clear occur in the same cycle, set wins;
  - reset value is 0.
- Undefined: both ports are absent and there is no irq logic.

Test Plan:
1. pattern 4'b1101, in_data 16'hD000 -> hit high at index 3 only; DONE with hit_count=1, first_hit_idx=3, no_hit=0; out_valid 17 cycles after the accept edge.
2. pattern 4'b1101, in_data 16'hDB60 (overlap) -> hit at indices 3, 6, 9; hit_count=3, first_hit_idx=3.
3. pattern 4'b1101, in_data 16'h0000 -> no hit pulses; hit_count=0, first_hit_idx=0, no_hit=1.
4. CNT_W=3, pattern 4'b0000, in_data 16'h0000 -> 13 raw matches; hit_count saturates at 7.
5. Result held with out_ready=0 for 5 cycles -> outputs stable, in_ready=0, in_valid ignored; raise out_ready -> IDLE, next word accepted one cycle later. Then change cfg_pattern during SHIFT -> result unchanged.
6. reset asserted at SHIFT index 8 -> immediate IDLE, in_ready=1, hit_count=0, out_valid never asserted; next word 16'hD000 scans correctly. With PATTERN_SCAN_IRQ_EN defined: irq sets on DONE of test 1 and clears on an irq_clr pulse.

Source files
------------

// File: rtl/pattern_scan_ctrl.sv
// ---------------------------------------------------------------------------
// pattern_scan_ctrl
//
// Purpose:
//   Accepts parallel words over a valid/ready handshake, shifts each word out
//   MSB-first through a bit-serial Mealy pattern matcher, counts overlapping
//   matches of a programmable PAT_W-bit pattern and reports the per-word
//   result over a second valid/ready handshake.
//
// Optional feature:
//   PATTERN_SCAN_IRQ_EN - when defined, adds a sticky irq output that is set
//   when a word finishes with at least one match. irq_clr clears it, and a
//   set in the same cycle as a clear wins.
//
// Ports:
//   clk            in   1       clock, rising edge
//   reset          in   1       asynchronous, active-high reset
//   cfg_pattern    in   PAT_W   pattern to match, MSB first in time (latched on accept)
//   in_valid       in   1       input word valid
//   in_ready       out  1       controller can accept a word (IDLE)
//   in_data        in   DATA_W  word to scan, bit DATA_W-1 scanned first
//   bit_out        out  1       bit being scanned this cycle, 0 outside SHIFT
//   hit            out  1       Mealy strobe, high in the cycle whose bit completes a match
//   busy           out  1       high in SHIFT and DONE
//   out_valid      out  1       result valid (DONE)
//   out_ready      in   1       result consumer ready
//   hit_count      out  CNT_W   saturating match count of the last word
//   first_hit_idx  out  IDX_W   scan index of the bit completing the first match, 0 if none
//   no_hit         out  1       high with out_valid when hit_count == 0
//   irq            out  1       sticky match interrupt (PATTERN_SCAN_IRQ_EN only)
//   irq_clr        in   1       clears irq (PATTERN_SCAN_IRQ_EN only)
// ---------------------------------------------------------------------------
module pattern_scan_ctrl #(
  parameter int DATA_W = 16,
  parameter int PAT_W  = 4,
  parameter int CNT_W  = 5,
  localparam int IDX_W = $clog2(DATA_W)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [PAT_W-1:0]  cfg_pattern,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              bit_out,
  output logic              hit,
  output logic              busy,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  hit_count,
  output logic [IDX_W-1:0]  first_hit_idx,
  output logic              no_hit
`ifdef PATTERN_SCAN_IRQ_EN
  ,
  output logic              irq,
  input  logic              irq_clr
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);
  localparam logic [IDX_W-1:0] MIN_IDX  = IDX_W'(PAT_W - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  state_t              state;
  state_t              state_next;
  logic [DATA_W-1:0]   shift_reg;
  logic [PAT_W-1:0]    pat_reg;
  logic [PAT_W-2:0]    history;
  logic [IDX_W-1:0]    idx;
  logic [PAT_W-1:0]    window;
  logic [CNT_W-1:0]    count_next;
  logic                accept;
  logic                last_bit;

  // The window is the last PAT_W-1 scanned bits plus the bit on the wire now,
  // so hit is a Mealy output. The index gate suppresses matches against the
  // zeroed history at the start of each word, so matches never span words.
  assign bit_out    = (state == SHIFT) & shift_reg[DATA_W-1];
  assign window     = {history, shift_reg[DATA_W-1]};
  assign hit        = (state == SHIFT) && (window == pat_reg) && (idx >= MIN_IDX);
  assign accept     = (state == IDLE) && in_valid;
  assign last_bit   = (state == SHIFT) && (idx == LAST_IDX);
  assign count_next = (hit && (hit_count != CNT_MAX)) ? hit_count + 1'b1 : hit_count;
  assign no_hit     = out_valid && (hit_count == '0);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and handshake outputs. DONE only returns to IDLE, so a new
  // word can never be accepted in the same cycle as the result handshake.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        if (idx == LAST_IDX) begin
          state_next = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Scan datapath. The pattern is captured with the word so later changes
  // to cfg_pattern cannot disturb a word in flight. Results only change in
  // SHIFT or on accept, so they hold steady while DONE waits for out_ready.
  // hit_count still at zero marks the first match of the word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_reg     <= '0;
      pat_reg       <= '0;
      history       <= '0;
      idx           <= '0;
      hit_count     <= '0;
      first_hit_idx <= '0;
    end else if (accept) begin
      shift_reg     <= in_data;
      pat_reg       <= cfg_pattern;
      history       <= '0;
      idx           <= '0;
      hit_count     <= '0;
      first_hit_idx <= '0;
    end else if (state == SHIFT) begin
      shift_reg <= shift_reg << 1;
      history   <= window[PAT_W-2:0];
      idx       <= idx + 1'b1;
      hit_count <= count_next;
      if (hit && (hit_count == '0)) begin
        first_hit_idx <= idx;
      end
    end
  end

`ifdef PATTERN_SCAN_IRQ_EN
  // Sticky interrupt, set on the transition into DONE using the count that
  // includes a possible match on the final bit; a set beats a clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq <= 1'b0;
    end else if (last_bit && (count_next != '0)) begin
      irq <= 1'b1;
    end else if (irq_clr) begin
      irq <= 1'b0;
    end
  end
`else
  logic unused_last_bit;
  assign unused_last_bit = last_bit;
`endif

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pattern_scan_ctrl
//
// Purpose:
//   Self-checking bench for pattern_scan_ctrl. Two instances share every
//   input: one with the default counter width and one with CNT_W=3 so the
//   saturating count can be exercised. Expected per-bit hits and per-word
//   results come from a reference model that slides a PAT_W-bit window over
//   the word arithmetically. Define PATTERN_SCAN_IRQ_EN to cover irq.
// ---------------------------------------------------------------------------
module tb_pattern_scan_ctrl;

  localparam int DATA_W = 16;
  localparam int PAT_W  = 4;
  localparam int CNT_W  = 5;
  localparam int SAT_W  = 3;
  localparam int IDX_W  = $clog2(DATA_W);

  logic              clk;
  logic              reset;
  logic [PAT_W-1:0]  cfg_pattern;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              out_ready;

  logic              in_ready;
  logic              bit_out;
  logic              hit;
  logic              busy;
  logic              out_valid;
  logic [CNT_W-1:0]  hit_count;
  logic [IDX_W-1:0]  first_hit_idx;
  logic              no_hit;

  logic              s_in_ready;
  logic              s_bit_out;
  logic              s_hit;
  logic              s_busy;
  logic              s_out_valid;
  logic [SAT_W-1:0]  s_hit_count;
  logic [IDX_W-1:0]  s_first_hit_idx;
  logic              s_no_hit;

`ifdef PATTERN_SCAN_IRQ_EN
  logic              irq;
  logic              s_irq;
  logic              irq_clr;
  logic              irq_model;
`endif

  int n_assert;
  int n_fail;

  pattern_scan_ctrl #(.DATA_W(DATA_W), .PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .cfg_pattern   (cfg_pattern),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .bit_out       (bit_out),
    .hit           (hit),
    .busy          (busy),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .hit_count     (hit_count),
    .first_hit_idx (first_hit_idx),
    .no_hit        (no_hit)
`ifdef PATTERN_SCAN_IRQ_EN
    ,
    .irq           (irq),
    .irq_clr       (irq_clr)
`endif
  );

  pattern_scan_ctrl #(.DATA_W(DATA_W), .PAT_W(PAT_W), .CNT_W(SAT_W)) dut_sat (
    .clk           (clk),
    .reset         (reset),
    .cfg_pattern   (cfg_pattern),
    .in_valid      (in_valid),
    .in_ready      (s_in_ready),
    .in_data       (in_data),
    .bit_out       (s_bit_out),
    .hit           (s_hit),
    .busy          (s_busy),
    .out_valid     (s_out_valid),
    .out_ready     (out_ready),
    .hit_count     (s_hit_count),
    .first_hit_idx (s_first_hit_idx),
    .no_hit        (s_no_hit)
`ifdef PATTERN_SCAN_IRQ_EN
    ,
    .irq           (s_irq),
    .irq_clr       (irq_clr)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: counted, and reported only when it fails.
  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: slide the pattern window over the word in scan order.
  function automatic void model_word(input logic [DATA_W-1:0] data, input logic [PAT_W-1:0] pat,
                                     output logic [DATA_W-1:0] hits, output int raw, output int first);
    logic [DATA_W-1:0] tmp;
    logic [PAT_W-1:0]  win;
    hits  = '0;
    raw   = 0;
    first = -1;
    for (int i = PAT_W - 1; i < DATA_W; i++) begin
      tmp = data >> (DATA_W - 1 - i);
      win = tmp[PAT_W-1:0];
      if (win == pat) begin
        hits[i] = 1'b1;
        raw++;
        if (first < 0) first = i;
      end
    end
  endfunction

  // Scan one word from IDLE back to IDLE. Starts and ends at a falling edge.
  // hold: extra DONE cycles with out_ready low. noise: drive in_valid with
  // junk data while busy. pat_change: flip cfg_pattern during SHIFT.
  task automatic apply_stimulus(input logic [DATA_W-1:0] data, input logic [PAT_W-1:0] pat,
                                input int hold, input bit noise, input bit pat_change);
    logic [DATA_W-1:0] hits;
    int                raw;
    int                first;
    int                exp_cnt;
    int                exp_sat;
    model_word(data, pat, hits, raw, first);
    exp_cnt = (raw > 31) ? 31 : raw;
    exp_sat = (raw > 7) ? 7 : raw;
    if (first < 0) first = 0;

    check_output("accept_in_ready", 32'(in_ready), 32'd1);
    in_data     = data;
    cfg_pattern = pat;
    in_valid    = 1'b1;
    @(negedge clk);
    in_valid = noise;
    if (pat_change) cfg_pattern = ~pat;

    for (int i = 0; i < DATA_W; i++) begin
      check_output($sformatf("bit_out[%0d]", i), 32'(bit_out), 32'(data[DATA_W-1-i]));
      check_output($sformatf("hit[%0d]", i), 32'(hit), 32'(hits[i]));
      check_output($sformatf("shift_in_ready[%0d]", i), 32'(in_ready), 32'd0);
      check_output($sformatf("shift_busy[%0d]", i), 32'(busy), 32'd1);
      check_output($sformatf("shift_out_valid[%0d]", i), 32'(out_valid), 32'd0);
      if (noise) in_data = DATA_W'($urandom);
      if (pat_change) cfg_pattern = PAT_W'($urandom);
      @(negedge clk);
    end

`ifdef PATTERN_SCAN_IRQ_EN
    if (raw > 0) irq_model = 1'b1;
`endif
    for (int h = 0; h <= hold; h++) begin
      check_output("done_out_valid", 32'(out_valid), 32'd1);
      check_output("done_in_ready", 32'(in_ready), 32'd0);
      check_output("done_bit_out", 32'(bit_out), 32'd0);
      check_output("done_hit", 32'(hit), 32'd0);
      check_output("hit_count", 32'(hit_count), 32'(exp_cnt));
      check_output("sat_hit_count", 32'(s_hit_count), 32'(exp_sat));
      check_output("first_hit_idx", 32'(first_hit_idx), 32'(first));
      check_output("no_hit", 32'(no_hit), 32'(raw == 0));
`ifdef PATTERN_SCAN_IRQ_EN
      check_output("irq", 32'(irq), 32'(irq_model));
`endif
      if (h < hold) begin
        if (noise) in_data = DATA_W'($urandom);
        @(negedge clk);
      end
    end

    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check_output("release_out_valid", 32'(out_valid), 32'd0);
    check_output("release_in_ready", 32'(in_ready), 32'd1);
    check_output("release_busy", 32'(busy), 32'd0);
  endtask

`ifdef PATTERN_SCAN_IRQ_EN
  task automatic clear_irq();
    irq_clr = 1'b1;
    @(negedge clk);
    irq_clr   = 1'b0;
    irq_model = 1'b0;
    check_output("irq_cleared", 32'(irq), 32'd0);
  endtask
`endif

  initial begin
    logic [DATA_W-1:0] rdata;
    logic [PAT_W-1:0]  rpat;
    logic [DATA_W-1:0] tmp;
    int                ofs;
    bit                saw_valid;

    n_assert    = 0;
    n_fail      = 0;
    reset       = 1'b1;
    cfg_pattern = '0;
    in_valid    = 1'b0;
    in_data     = '0;
    out_ready   = 1'b0;
`ifdef PATTERN_SCAN_IRQ_EN
    irq_clr   = 1'b0;
    irq_model = 1'b0;
`endif
    $display("[TB] start");
    repeat (2) @(negedge clk);
    check_output("rst_in_ready", 32'(in_ready), 32'd1);
    check_output("rst_busy", 32'(busy), 32'd0);
    check_output("rst_out_valid", 32'(out_valid), 32'd0);
    check_output("rst_bit_out", 32'(bit_out), 32'd0);
    check_output("rst_hit", 32'(hit), 32'd0);
    check_output("rst_hit_count", 32'(hit_count), 32'd0);
    check_output("rst_first_hit_idx", 32'(first_hit_idx), 32'd0);
    check_output("rst_no_hit", 32'(no_hit), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    $display("[TB] single match");
    apply_stimulus(16'hD000, 4'b1101, 0, 1'b0, 1'b0);
`ifdef PATTERN_SCAN_IRQ_EN
    clear_irq();
`endif

    $display("[TB] overlapping matches");
    apply_stimulus(16'hDB60, 4'b1101, 0, 1'b0, 1'b0);

    $display("[TB] no match");
    apply_stimulus(16'h0000, 4'b1101, 0, 1'b0, 1'b0);

    $display("[TB] saturation");
    apply_stimulus(16'h0000, 4'b0000, 0, 1'b0, 1'b0);

    $display("[TB] hold with out_ready low, back-to-back word, pattern change in flight");
    apply_stimulus(16'hDB60, 4'b1101, 5, 1'b1, 1'b0);
    apply_stimulus(16'hD000, 4'b1101, 0, 1'b0, 1'b1);
    apply_stimulus(16'hB6DB, 4'b1011, 2, 1'b1, 1'b1);

    $display("[TB] reset mid-shift");
    check_output("pre_rst_in_ready", 32'(in_ready), 32'd1);
    in_data     = 16'hFFFF;
    cfg_pattern = 4'b1111;
    in_valid    = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (8) @(negedge clk);
    reset = 1'b1;
    #1;
    check_output("abort_in_ready", 32'(in_ready), 32'd1);
    check_output("abort_busy", 32'(busy), 32'd0);
    check_output("abort_out_valid", 32'(out_valid), 32'd0);
    check_output("abort_hit_count", 32'(hit_count), 32'd0);
    check_output("abort_bit_out", 32'(bit_out), 32'd0);
    check_output("abort_first_hit_idx", 32'(first_hit_idx), 32'd0);
`ifdef PATTERN_SCAN_IRQ_EN
    irq_model = 1'b0;
    check_output("abort_irq", 32'(irq), 32'd0);
`endif
    @(negedge clk);
    reset     = 1'b0;
    saw_valid = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) saw_valid = 1'b1;
    end
    check_output("abort_no_out_valid", 32'(saw_valid), 32'd0);
    apply_stimulus(16'hD000, 4'b1101, 0, 1'b0, 1'b0);

    $display("[TB] random words");
    for (int r = 0; r < 8; r++) begin
      rdata = DATA_W'($urandom);
      if (r[0]) begin
        ofs  = int'($urandom_range(DATA_W - PAT_W, 0));
        tmp  = rdata >> ofs;
        rpat = tmp[PAT_W-1:0];
      end else begin
        rpat = PAT_W'($urandom);
      end
      apply_stimulus(rdata, rpat, int'($urandom_range(3, 0)), r[1], r[2]);
`ifdef PATTERN_SCAN_IRQ_EN
      clear_irq();
`endif
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
